// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the ALU. It captures decoded fields and forwards results from MEM and WB into the operands.
// It detects load-use hazards and inserts a single bubble when one occurs.
module id_ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_rd_wren,
    input  logic            id_is_load,
    input  logic [3:0]      id_alu_op,
    input  logic            id_opa_sel,
    input  logic            id_opb_sel,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_rd_wren,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_rd_wren,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_stall,
    input  logic            flush,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [3:0]      alu_op,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_rd_wren,
    output logic            ex_is_load,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d;
    logic [4:0]      rs2_addr_q, rs2_addr_d;
    logic [4:0]      rd_addr_q,  rd_addr_d;
    logic            rd_wren_q,  rd_wren_d;
    logic            is_load_q,  is_load_d;
    logic [3:0]      alu_op_q,   alu_op_d;
    logic            opa_sel_q,  opa_sel_d;
    logic            opb_sel_q,  opb_sel_d;

    logic            wb_hit_rs1, wb_hit_rs2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rd_addr = rd_addr_q;
    assign ex_rd_wren = valid_q & rd_wren_q;
    assign ex_is_load = valid_q & is_load_q;
    assign alu_op     = alu_op_q;

    always_comb begin
        load_use_stall = id_valid & ex_is_load & (rd_addr_q != 5'd0) & ~flush &
                         ((id_rs1_used & (id_rs1_addr == rd_addr_q)) |
                          (id_rs2_used & (id_rs2_addr == rd_addr_q)));
    end

    assign wb_hit_rs1 = wb_rd_wren & (wb_rd_addr != 5'd0) & (wb_rd_addr == rs1_addr_q);
    assign wb_hit_rs2 = wb_rd_wren & (wb_rd_addr != 5'd0) & (wb_rd_addr == rs2_addr_q);

    // MEM is the younger producer, so it wins over WB. x0 always uses the captured value.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_rd_wren && mem_rd_addr != 5'd0 && mem_rd_addr == rs1_addr_q)
            fwd_rs1 = mem_fwd_data;
        else if (wb_hit_rs1)
            fwd_rs1 = wb_data;

        fwd_rs2 = rs2_data_q;
        if (mem_rd_wren && mem_rd_addr != 5'd0 && mem_rd_addr == rs2_addr_q)
            fwd_rs2 = mem_fwd_data;
        else if (wb_hit_rs2)
            fwd_rs2 = wb_data;
    end

    assign operand_a     = opa_sel_q ? pc_q  : fwd_rs1;
    assign operand_b     = opb_sel_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_wren_d  = rd_wren_q;
        is_load_d  = is_load_q;
        alu_op_d   = alu_op_q;
        opa_sel_d  = opa_sel_q;
        opb_sel_d  = opb_sel_q;

        if (flush) begin
            valid_d   = 1'b0;
            rd_wren_d = 1'b0;
            is_load_d = 1'b0;
        end else if (ex_stall) begin
            // WB may retire the producer while EX is held; keep its value so it is not lost.
            if (wb_hit_rs1) rs1_data_d = wb_data;
            if (wb_hit_rs2) rs2_data_d = wb_data;
        end else if (load_use_stall) begin
            valid_d   = 1'b0;
            rd_wren_d = 1'b0;
            is_load_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_addr_d = id_rs1_addr;
            rs2_addr_d = id_rs2_addr;
            rd_addr_d  = id_rd_addr;
            rd_wren_d  = id_rd_wren;
            is_load_d  = id_is_load;
            alu_op_d   = id_alu_op;
            opa_sel_d  = id_opa_sel;
            opb_sel_d  = id_opb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rd_wren_q  <= 1'b0;
            is_load_q  <= 1'b0;
            alu_op_q   <= '0;
            opa_sel_q  <= 1'b0;
            opb_sel_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_wren_q  <= rd_wren_d;
            is_load_q  <= is_load_d;
            alu_op_q   <= alu_op_d;
            opa_sel_q  <= opa_sel_d;
            opb_sel_q  <= opb_sel_d;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage. Directed hazard scenarios run first, then random traffic.
// All traffic is checked against a transaction-level model of the EX slot.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wren, id_is_load, id_opa_sel, id_opb_sel;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_fwd_data, wb_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
    logic        mem_rd_wren, wb_rd_wren, ex_stall, flush;
    logic [3:0]  id_alu_op;
    logic [31:0] operand_a, operand_b, ex_pc, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_rd_wren, ex_is_load, load_use_stall;
    logic [4:0]  ex_rd_addr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_wren(id_rd_wren), .id_is_load(id_is_load),
        .id_alu_op(id_alu_op), .id_opa_sel(id_opa_sel), .id_opb_sel(id_opb_sel),
        .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren), .mem_fwd_data(mem_fwd_data),
        .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_rd_wren(ex_rd_wren), .ex_is_load(ex_is_load),
        .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
    );

    // Reference: the instruction sitting in EX, as a plain record
    typedef struct {
        bit          v;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  a1, a2, rd;
        bit          wren, ld, sa, sb;
        logic [3:0]  op;
    } ex_t;
    ex_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] source_val(input logic [4:0] a, input logic [31:0] cap);
        if (a == 0) return cap;
        if (mem_rd_wren && mem_rd_addr == a) return mem_fwd_data;
        if (wb_rd_wren && wb_rd_addr == a) return wb_data;
        return cap;
    endfunction

    function automatic bit exp_lus();
        return id_valid && m.v && m.ld && m.rd != 0 && !flush &&
               ((id_rs1_used && id_rs1_addr == m.rd) || (id_rs2_used && id_rs2_addr == m.rd));
    endfunction

    task automatic idle();
        rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd_addr = 0; id_rd_wren = 0; id_is_load = 0; id_alu_op = 0;
        id_opa_sel = 0; id_opb_sel = 0; mem_rd_addr = 0; mem_rd_wren = 0; mem_fwd_data = 0;
        wb_rd_addr = 0; wb_rd_wren = 0; wb_data = 0; ex_stall = 0; flush = 0;
    endtask

    // Compare all outputs against the model, advance the model, then cross one clock edge
    task automatic cycle();
        bit lus;
        #1;
        lus = exp_lus();
        check("ex_valid",   ex_valid,   m.v);
        check("ex_pc",      ex_pc,      m.pc);
        check("ex_rd_addr", ex_rd_addr, m.rd);
        check("ex_rd_wren", ex_rd_wren, m.v & m.wren);
        check("ex_is_load", ex_is_load, m.v & m.ld);
        check("alu_op",     alu_op,     m.op);
        check("operand_a",  operand_a,  m.sa ? m.pc : source_val(m.a1, m.rs1));
        check("operand_b",  operand_b,  m.sb ? m.imm : source_val(m.a2, m.rs2));
        check("store_data", ex_store_data, source_val(m.a2, m.rs2));
        check("load_use",   load_use_stall, lus);
        if (rst) begin
            m = '{default: 0};
        end else if (flush) begin
            m.v = 0; m.wren = 0; m.ld = 0;
        end else if (ex_stall) begin
            if (wb_rd_wren && wb_rd_addr != 0 && wb_rd_addr == m.a1) m.rs1 = wb_data;
            if (wb_rd_wren && wb_rd_addr != 0 && wb_rd_addr == m.a2) m.rs2 = wb_data;
        end else if (lus) begin
            m.v = 0; m.wren = 0; m.ld = 0;
        end else begin
            m = '{v: id_valid, pc: id_pc, rs1: id_rs1_data, rs2: id_rs2_data, imm: id_imm,
                  a1: id_rs1_addr, a2: id_rs2_addr, rd: id_rd_addr, wren: id_rd_wren,
                  ld: id_is_load, sa: id_opa_sel, sb: id_opb_sel, op: id_alu_op};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        m = '{default: 0};

        // Reset while ID presents a valid instruction
        rst = 1; id_valid = 1; id_alu_op = 4'd5; id_pc = 32'h100; id_rd_wren = 1;
        id_rs1_data = 32'h11; id_rs2_data = 32'h22;
        cycle();
        check("rst_valid", ex_valid, 1'b0);
        check("rst_alu_op", alu_op, 4'd0);
        check("rst_opa", operand_a, 32'd0);
        check("rst_opb", operand_b, 32'd0);
        check("rst_lus", load_use_stall, 1'b0);

        // ADD x3,x1,x2 where both MEM and WB are writing x1
        idle(); id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rs1_used = 1; id_rs2_used = 1;
        id_rs1_data = 5; id_rs2_data = 7; id_rd_addr = 3; id_rd_wren = 1;
        cycle();
        idle(); mem_rd_wren = 1; mem_rd_addr = 1; mem_fwd_data = 100;
        wb_rd_wren = 1; wb_rd_addr = 1; wb_data = 50;
        #1;
        check("fwd_mem_a", operand_a, 32'd100);
        check("fwd_b", operand_b, 32'd7);
        cycle();

        // LW x4, followed by ADD x5,x4,x0
        idle(); id_valid = 1; id_is_load = 1; id_rd_addr = 4; id_rd_wren = 1; id_opb_sel = 1;
        cycle();
        idle(); id_valid = 1; id_rs1_addr = 4; id_rs2_addr = 0; id_rs1_used = 1; id_rs2_used = 1;
        id_rd_addr = 5; id_rd_wren = 1;
        #1;
        check("lu_stall", load_use_stall, 1'b1);
        cycle();
        check("lu_bubble", ex_valid, 1'b0);
        check("lu_release", load_use_stall, 1'b0);
        cycle();
        check("lu_capture_v", ex_valid, 1'b1);
        check("lu_capture_rd", ex_rd_addr, 32'd5);

        // Stall for two cycles while WB retires x6
        idle(); id_valid = 1; id_rs2_addr = 6; id_rs2_used = 1; id_rs2_data = 0; id_rd_addr = 7; id_rd_wren = 1;
        cycle();
        idle(); ex_stall = 1; wb_rd_wren = 1; wb_rd_addr = 6; wb_data = 32'hDEAD;
        cycle();
        wb_rd_wren = 0; wb_data = 0;
        #1;
        check("stall_hold_b", operand_b, 32'hDEAD);
        cycle();
        check("stall_end_b", operand_b, 32'hDEAD);
        check("stall_end_sd", ex_store_data, 32'hDEAD);

        // A flush wins over the stall
        idle(); id_valid = 1; id_rd_addr = 9; id_rd_wren = 1;
        cycle();
        idle(); flush = 1; ex_stall = 1;
        cycle();
        check("flush_valid", ex_valid, 1'b0);
        check("flush_wren", ex_rd_wren, 1'b0);

        // x0 is never forwarded, and the PC can be selected for operand A
        idle(); id_valid = 1; id_rs1_addr = 0; id_rs1_used = 1;
        mem_rd_wren = 1; mem_rd_addr = 0; mem_fwd_data = 32'hFFFF;
        cycle();
        check("x0_nofwd", operand_a, 32'd0);
        idle(); id_valid = 1; id_opa_sel = 1; id_pc = 32'h40;
        cycle();
        check("pc_sel", operand_a, 32'h40);

        // Random traffic on a small register window to provoke frequent hazards
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_pc        = $urandom;
            id_imm       = $urandom;
            id_rs1_addr  = 5'($urandom_range(0, 7));
            id_rs2_addr  = 5'($urandom_range(0, 7));
            id_rs1_data  = (id_rs1_addr == 0) ? 32'd0 : $urandom;
            id_rs2_data  = (id_rs2_addr == 0) ? 32'd0 : $urandom;
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            id_rd_addr   = 5'($urandom_range(0, 7));
            id_rd_wren   = 1'($urandom_range(0, 1));
            id_is_load   = ($urandom_range(0, 2) == 0);
            id_alu_op    = 4'($urandom_range(0, 9));
            id_opa_sel   = 1'($urandom_range(0, 1));
            id_opb_sel   = 1'($urandom_range(0, 1));
            mem_rd_addr  = 5'($urandom_range(0, 7));
            mem_rd_wren  = 1'($urandom_range(0, 1));
            mem_fwd_data = $urandom;
            wb_rd_addr   = 5'($urandom_range(0, 7));
            wb_rd_wren   = 1'($urandom_range(0, 1));
            wb_data      = $urandom;
            ex_stall     = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
